// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: bundles the receiver's line-side inputs and byte-side outputs.
//   sample_tick_i  oversample strobe (OVERSAMPLE x baud)
//   receive_i      serial line, idle high
//   data_o         last received word, LSB = first data bit on the line
//   ready_o        one-cycle pulse per completed frame
//   parity_err_o   parity mismatch in the last frame
//   frame_err_o    a stop bit of the last frame was low
//   busy_o         receiver is not idle
// slave = the receiver, master = whoever drives the line and consumes words.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 sample_tick_i;
  logic                 receive_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 ready_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 busy_o;

  modport slave (
    input  sample_tick_i, receive_i,
    output data_o, ready_o, parity_err_o, frame_err_o, busy_o
  );

  modport master (
    output sample_tick_i, receive_i,
    input  data_o, ready_o, parity_err_o, frame_err_o, busy_o
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling asynchronous serial receiver.
// 5..9 data bits, optional odd/even parity, 1 or 2 stop bits; start bit is
// validated at mid-bit, every later bit is sampled OVERSAMPLE ticks apart.
// Ports:
//   sysclk  clock, rising edge
//   reset   asynchronous, active high
//   rx      uart_rx_core_if.slave (tick, line in; word, flags, ready, busy out)
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input logic           sysclk,
  input logic           reset,
  uart_rx_core_if.slave rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic                 stopcnt_q, stopcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 pacc_q, pacc_d;   // parity error of the frame in flight
  logic                 facc_q, facc_d;   // low stop sample seen so far
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ready_q, ready_d;

  logic tick, rx_s, at_mid, at_full, ferr_now;

  assign tick     = rx.sample_tick_i;
  assign rx_s     = sync_q[1];
  assign at_mid   = (tcnt_q == TW'(OVERSAMPLE/2 - 1));
  assign at_full  = (tcnt_q == TW'(OVERSAMPLE - 1));
  assign ferr_now = facc_q | ~rx_s;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    pacc_d    = pacc_q;
    facc_d    = facc_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ready_d   = 1'b0;
    case (state_q)
      S_IDLE: if (tick && !rx_s) begin
        tcnt_d  = '0;
        state_d = S_START;
      end
      S_START: if (tick) begin
        if (!at_mid) tcnt_d = tcnt_q + 1'b1;
        else if (rx_s) state_d = S_IDLE;        // glitch, nothing reported
        else begin
          tcnt_d   = '0;
          bitcnt_d = '0;
          state_d  = S_DATA;
        end
      end
      S_DATA: if (tick) begin
        if (!at_full) tcnt_d = tcnt_q + 1'b1;
        else begin
          tcnt_d   = '0;
          shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BW'(DATA_BITS - 1)) begin
            pacc_d    = 1'b0;
            facc_d    = 1'b0;
            stopcnt_d = 1'b0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: if (tick) begin
        if (!at_full) tcnt_d = tcnt_q + 1'b1;
        else begin
          tcnt_d  = '0;
          // XOR over data+parity must be 1 for odd, 0 for even
          pacc_d  = (^shreg_q) ^ rx_s ^ (PARITY == 1);
          state_d = S_STOP;
        end
      end
      S_STOP: if (tick) begin
        if (!at_full) tcnt_d = tcnt_q + 1'b1;
        else begin
          tcnt_d = '0;
          if (stopcnt_q == 1'(STOP_BITS - 1)) begin
            data_d  = shreg_q;
            perr_d  = (PARITY != 0) && pacc_q;
            ferr_d  = ferr_now;
            ready_d = 1'b1;
            // a low final stop means the line is still low: wait it out so
            // a break produces a single frame
            state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
          end else begin
            facc_d    = ferr_now;
            stopcnt_d = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: if (tick && rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;   // idle-high so reset release cannot fake a start
      tcnt_q    <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      shreg_q   <= '0;
      data_q    <= '0;
      pacc_q    <= 1'b0;
      facc_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], rx.receive_i};
      tcnt_q    <= tcnt_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      pacc_q    <= pacc_d;
      facc_q    <= facc_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ready_q   <= ready_d;
    end
  end

  assign rx.data_o       = data_q;
  assign rx.ready_o      = ready_q;
  assign rx.parity_err_o = perr_q;
  assign rx.frame_err_o  = ferr_q;
  assign rx.busy_o       = (state_q != S_IDLE);
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised asynchronous serial receiver; successor to the fixed 8N2 receiver. It oversamples the line with an external tick and validates the start bit at mid-bit. It supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits, and reports parity and framing errors per frame. It sits between the pad-side `receive_i` line and the byte-consuming logic; the tick comes from the shared baud generator.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `PARITY`, default 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `OVERSAMPLE`, default 16: sample ticks per bit, even, legal 8..32.

Ports:
- `sysclk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sample_tick_i` in 1: one-cycle strobe at OVERSAMPLE × baud.
- `receive_i` in 1: serial line, idle high, asynchronous to `sysclk`.
- `data_o` out DATA_BITS: last received word, LSB = first data bit on the line.
- `ready_o` out 1: one-cycle pulse, new frame complete.
- `parity_err_o` out 1: parity mismatch in the last frame; constant 0 when PARITY=0.
- `frame_err_o` out 1: a stop bit in the last frame was sampled low.
- `busy_o` out 1: high while not in IDLE.

## Operation
- `receive_i` passes through a 2-flop synchroniser (`rx_s`) before any use.
- Tick counter `tcnt` has width clog2(OVERSAMPLE) and advances only on `sample_tick_i`.
- State machine:
  - IDLE: on a tick with `rx_s`=0, clear `tcnt` and go to START.
  - START: on the tick where `tcnt` = OVERSAMPLE/2−1, sample `rx_s`. If 1, treat it as a glitch: return to IDLE with no outputs changed. If 0, clear `tcnt`, clear `bitcnt`, and go to DATA.
  - DATA: on the tick where `tcnt` = OVERSAMPLE−1, shift `rx_s` in LSB-first. At the sample where `bitcnt` = DATA_BITS−1, go to PARITY if PARITY≠0, else STOP.
  - PARITY: sample one bit after OVERSAMPLE ticks. Error if XOR(data, parity bit) ≠ 1 for odd, or ≠ 0 for even.
  - STOP: sample STOP_BITS bits at OVERSAMPLE-tick spacing. Any low sample sets the frame error. After the last stop sample:
    - load `data_o`, `parity_err_o` and `frame_err_o` together;
    - pulse `ready_o`;
    - go to IDLE if the last stop sample was 1, else go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1 on a tick, then go to IDLE. A line held low (break) yields exactly one frame with `frame_err_o`=1 and data all zero.
- Illegal state encodings recover to IDLE. No simulation stop.
- Outputs `data_o`, `parity_err_o` and `frame_err_o` hold their values until the next `ready_o`.

## Timing
- Reset values: `data_o`=0, `ready_o`=0, `parity_err_o`=0, `frame_err_o`=0, `busy_o`=0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately: no `ready_o`, outputs go to reset values.
- Latency: `ready_o` rises 1 `sysclk` after the clock edge carrying the tick of the final stop-bit sample. Synchroniser delay from the line is 2 cycles.
- `data_o` and the error flags change on the same edge that `ready_o` rises, and are valid while `ready_o`=1.
- `ready_o` is high for exactly one cycle per accepted frame. There is no back-pressure; the consumer must take data within one frame time.
- `busy_o` rises on the edge of the IDLE→START transition and falls on the edge of the transition into IDLE.
- A falling edge arriving in the same tick as the final stop sample is not detected until the next tick in IDLE. Start of the next frame is back-to-back capable with 1 stop bit.
- Ticks arriving on consecutive `sysclk` cycles are legal. The design counts ticks, not clocks.

## Test plan
- Defaults (8N1, OVERSAMPLE=16): send 0xA5, then 0x3C back-to-back → two `ready_o` pulses, `data_o`=0xA5 then 0x3C, both error flags 0.
- PARITY=2, DATA_BITS=7: send 0x55 with a correct parity bit (0), then 0x55 with the parity bit flipped → first frame `parity_err_o`=0, second frame `parity_err_o`=1, `data_o`=0x55 both times.
- STOP_BITS=2: send 0xFF with the second stop bit forced low → `frame_err_o`=1 and `ready_o` pulses once. FSM stays in WAIT_IDLE until the line returns high; the next frame 0x12 receives cleanly with `frame_err_o`=0.
- Start glitch: drive the line low for 5 ticks, then high (OVERSAMPLE=16) → no `ready_o`, and `busy_o` returns to 0 at tick 8.
- Break: hold the line low for 30 bit times → exactly one `ready_o`, `data_o`=0, `frame_err_o`=1; no further pulses until the line goes high and a new frame is sent.
- Reset during DATA (after 4 bits of 0xC3) → all outputs 0 and no `ready_o`; a following full 0xC3 frame receives correctly.
